// File: rtl/ringbuf_1ch.sv
// rtl/ringbuf_1ch.sv - per-channel sample ring buffer with random-access FIR window read
// Optional: define RINGBUF_ZEROFILL_EN to read zero for offsets at or beyond the current level.
module ringbuf_1ch #(
   parameter int WIDTH      = 24,
   parameter int DEPTH      = 64,
   parameter int DEPTH_LOG2 = 6,
   parameter int WINDOW     = 16,
   parameter int OFFSET_W   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic [WIDTH-1:0]      data_i,
   output logic                  full_o,
   input  logic                  pop_i,
   input  logic [OFFSET_W-1:0]   offset_i,
   output logic [WIDTH-1:0]      data_o,
   output logic                  window_valid_o,
   output logic [DEPTH_LOG2:0]   level_o,
   output logic                  overflow_o,
   output logic                  underflow_o,
   input  logic                  clr_flags_i
);

   localparam logic [DEPTH_LOG2:0] LEVEL_FULL   = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] LEVEL_WINDOW = (DEPTH_LOG2+1)'(WINDOW);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
   logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
   logic [DEPTH_LOG2:0]   level_q, level_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  push_acc, pop_acc;
   logic [DEPTH_LOG2-1:0] rd_addr;

   // A pop frees a slot in the same cycle, so a push at full still lands.
   always_comb begin
      pop_acc  = pop_i && (level_q != '0);
      push_acc = push_i && ((level_q != LEVEL_FULL) || pop_acc);

      wptr_d = wptr_q;
      rptr_d = rptr_q;
      level_d = level_q;
      if (push_acc) wptr_d = wptr_q + DEPTH_LOG2'(1);
      if (pop_acc)  rptr_d = rptr_q + DEPTH_LOG2'(1);
      if (push_acc && !pop_acc) level_d = level_q + (DEPTH_LOG2+1)'(1);
      if (pop_acc && !push_acc) level_d = level_q - (DEPTH_LOG2+1)'(1);

      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (clr_flags_i) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (push_i && !push_acc)              overflow_d  = 1'b1;
      if (pop_i && (level_q < LEVEL_WINDOW)) underflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_acc && !rst) mem[wptr_q] <= data_i;
   end

   assign rd_addr = rptr_q + DEPTH_LOG2'(offset_i);

`ifdef RINGBUF_ZEROFILL_EN
   assign data_o = ((DEPTH_LOG2+1)'(offset_i) >= level_q) ? '0 : mem[rd_addr];
`else
   assign data_o = mem[rd_addr];
`endif

   assign full_o         = (level_q == LEVEL_FULL);
   assign window_valid_o = (level_q >= LEVEL_WINDOW);
   assign level_o        = level_q;
   assign overflow_o     = overflow_q;
   assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_ringbuf_1ch.sv
// tb/tb_ringbuf_1ch.sv - randomized and directed bench for ringbuf_1ch against a queue model
module tb_ringbuf_1ch;
   localparam int WIDTH      = 24;
   localparam int DEPTH      = 64;
   localparam int DEPTH_LOG2 = 6;
   localparam int WINDOW     = 16;
   localparam int OFFSET_W   = 4;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                push_i = 1'b0;
   logic [WIDTH-1:0]    data_i = '0;
   logic                full_o;
   logic                pop_i = 1'b0;
   logic [OFFSET_W-1:0] offset_i = '0;
   logic [WIDTH-1:0]    data_o;
   logic                window_valid_o;
   logic [DEPTH_LOG2:0] level_o;
   logic                overflow_o;
   logic                underflow_o;
   logic                clr_flags_i = 1'b0;

   ringbuf_1ch #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .DEPTH_LOG2(DEPTH_LOG2),
      .WINDOW(WINDOW), .OFFSET_W(OFFSET_W)
   ) dut (
      .clk(clk), .rst(rst), .push_i(push_i), .data_i(data_i), .full_o(full_o),
      .pop_i(pop_i), .offset_i(offset_i), .data_o(data_o),
      .window_valid_o(window_valid_o), .level_o(level_o),
      .overflow_o(overflow_o), .underflow_o(underflow_o), .clr_flags_i(clr_flags_i)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [WIDTH-1:0] mq[$];
   bit               m_ovf = 1'b0;
   bit               m_unf = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_step(input bit p, input logic [WIDTH-1:0] d, input bit po, input bit clr);
      bit pop_acc;
      bit push_acc;
      int n;
      n        = mq.size();
      pop_acc  = po && (n > 0);
      push_acc = p && ((n < DEPTH) || pop_acc);
      if (clr) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
      if (p && !push_acc) m_ovf = 1'b1;
      if (po && (n < WINDOW)) m_unf = 1'b1;
      if (pop_acc) void'(mq.pop_front());
      if (push_acc) mq.push_back(d);
   endtask

   task automatic cycle(input bit p, input logic [WIDTH-1:0] d, input bit po, input bit clr);
      @(negedge clk);
      push_i = p; data_i = d; pop_i = po; clr_flags_i = clr;
      @(posedge clk);
      model_step(p, d, po, clr);
      #1;
      push_i = 1'b0; pop_i = 1'b0; clr_flags_i = 1'b0;
   endtask

   task automatic do_reset(input bit busy);
      @(negedge clk);
      rst = 1'b1; push_i = busy; pop_i = busy; data_i = 24'h5EED00;
      @(posedge clk);
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      #1;
      rst = 1'b0; push_i = 1'b0; pop_i = 1'b0;
   endtask

   task automatic check_off(input string tag, input int k);
      offset_i = OFFSET_W'(k);
      #1;
      if (k < mq.size()) check_val(tag, 32'(data_o), 32'(mq[k]));
`ifdef RINGBUF_ZEROFILL_EN
      else check_val(tag, 32'(data_o), 32'd0);
`endif
   endtask

   task automatic check_state(input string tag);
      check_val({tag, ".level"}, 32'(level_o), 32'(mq.size()));
      check_val({tag, ".full"},  32'(full_o), 32'(mq.size() == DEPTH));
      check_val({tag, ".wv"},    32'(window_valid_o), 32'(mq.size() >= WINDOW));
      check_val({tag, ".ovf"},   32'(overflow_o), 32'(m_ovf));
      check_val({tag, ".unf"},   32'(underflow_o), 32'(m_unf));
      check_off({tag, ".data"}, int'($urandom_range(0, 2**OFFSET_W - 1)));
   endtask

   initial begin
      int popped;
      int k;
      int pct;

      do_reset(1'b0);
      check_val("rst.level", 32'(level_o), 32'd0);
      check_val("rst.full",  32'(full_o), 32'd0);
      check_val("rst.wv",    32'(window_valid_o), 32'd0);
      check_val("rst.flags", 32'({overflow_o, underflow_o}), 32'd0);

      for (int i = 1; i <= 16; i++) cycle(1'b1, 24'(i), 1'b0, 1'b0);
      check_val("fill16.level", 32'(level_o), 32'd16);
      check_val("fill16.wv", 32'(window_valid_o), 32'd1);
      offset_i = 4'd0;  #1; check_val("fill16.off0", 32'(data_o), 32'h1);
      offset_i = 4'd15; #1; check_val("fill16.off15", 32'(data_o), 32'h10);

      cycle(1'b0, '0, 1'b1, 1'b0);
      check_val("pop1.level", 32'(level_o), 32'd15);
      check_val("pop1.wv", 32'(window_valid_o), 32'd0);
      check_val("pop1.unf", 32'(underflow_o), 32'd0);
      offset_i = 4'd0; #1; check_val("pop1.off0", 32'(data_o), 32'h2);
      cycle(1'b0, '0, 1'b1, 1'b0);
      check_val("pop2.level", 32'(level_o), 32'd14);
      check_val("pop2.unf", 32'(underflow_o), 32'd1);
      cycle(1'b0, '0, 1'b0, 1'b1);
      check_val("clr1.unf", 32'(underflow_o), 32'd0);

      while (mq.size() < DEPTH) cycle(1'b1, 24'h100 + 24'(mq.size()), 1'b0, 1'b0);
      check_state("full");
      cycle(1'b1, 24'hABCDEF, 1'b0, 1'b0);
      check_val("ovf.flag", 32'(overflow_o), 32'd1);
      check_val("ovf.level", 32'(level_o), 32'd64);
      offset_i = 4'd0; #1; check_val("ovf.oldest", 32'(data_o), 32'h3);
      cycle(1'b0, '0, 1'b0, 1'b1);
      check_val("clr2.ovf", 32'(overflow_o), 32'd0);

      cycle(1'b1, 24'h5A5A5A, 1'b1, 1'b0);
      check_val("fullpp.level", 32'(level_o), 32'd64);
      check_val("fullpp.ovf", 32'(overflow_o), 32'd0);
      for (int i = 0; i < 48; i++) cycle(1'b0, '0, 1'b1, 1'b0);
      check_val("fullpp.unf", 32'(underflow_o), 32'd0);
      offset_i = 4'd15; #1; check_val("fullpp.newest", 32'(data_o), 32'h5A5A5A);

      while (mq.size() > 0) cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b1);
      check_state("empty");
      cycle(1'b1, 24'h777777, 1'b1, 1'b0);
      check_val("emptypp.level", 32'(level_o), 32'd1);
      check_val("emptypp.unf", 32'(underflow_o), 32'd1);
      offset_i = 4'd0; #1; check_val("emptypp.off0", 32'(data_o), 32'h777777);

      // Wrap-around: steady level 20, sample values are sequential so window is pure arithmetic
      do_reset(1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b1, 24'h10000 + 24'(i), 1'b0, 1'b0);
      popped = 0;
      for (int i = 0; i < 200; i++) begin
         cycle(1'b1, 24'h10000 + 24'(20 + i), 1'b1, 1'b0);
         popped++;
         k = int'($urandom_range(0, 15));
         offset_i = OFFSET_W'(k);
         #1;
         check_val("wrap.data", 32'(data_o), 32'h10000 + 32'(popped + k));
         check_val("wrap.level", 32'(level_o), 32'd20);
      end
      check_val("wrap.flags", 32'({overflow_o, underflow_o}), 32'd0);

      for (int ph = 0; ph < 4; ph++) begin
         pct = (ph == 0) ? 85 : (ph == 2) ? 15 : 50;
         for (int i = 0; i < 250; i++) begin
            cycle(($urandom_range(0, 99) < pct), 24'($urandom),
                  ($urandom_range(0, 99) >= pct), ($urandom_range(0, 19) == 0));
            check_state("rand");
         end
      end

      do_reset(1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 24'hC0FFE0 + 24'(i), 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) check_off("short.off", i);
      offset_i = 4'd2; #1; check_val("short.off2", 32'(data_o), 32'hC0FFE2);

      cycle(1'b0, '0, 1'b1, 1'b0);
      while (mq.size() < DEPTH) cycle(1'b1, 24'(mq.size()), 1'b0, 1'b0);
      cycle(1'b1, 24'h123456, 1'b0, 1'b0);
      check_val("prerst.flags", 32'({overflow_o, underflow_o}), 32'd3);
      do_reset(1'b1);
      check_val("midrst.level", 32'(level_o), 32'd0);
      check_val("midrst.flags", 32'({overflow_o, underflow_o}), 32'd0);
      check_val("midrst.full", 32'(full_o), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
